multicycle_control: RTL
=======================

// Module: multicycle_control
// PURPOSE
//  Main control FSM of the multicycle MIPS datapath; sits directly upstream of alu_control.
//  Decodes opcode from the instruction register, sequences fetch/decode/execute/memory/writeback,
//  drives datapath mux selects and write enables, and supplies alu_op[1:0] to alu_control.
//  Moore machine; all outputs decode from the current state only.
// PARAMETERS
//  MEM_WAIT      1  1: FETCH/MEMREAD/MEMWRITE hold until mem_ready=1; 0: mem_ready ignored, treated as 1
//  TRAP_ILLEGAL  0  1: illegal opcode parks FSM in ILLEGAL until reset; 0: returns to FETCH
// PORTS
//  clk            in   1  rising-edge clock
//  rst_n          in   1  asynchronous active-low reset
//  opcode         in   6  instr[31:26] from instruction register
//  mem_ready      in   1  memory access complete this cycle
//  pc_write       out  1  unconditional PC write
//  pc_write_cond  out  1  PC write if ALU zero (beq)
//  iord           out  1  0: mem addr=PC, 1: mem addr=ALUOut
//  mem_read       out  1  memory read strobe
//  mem_write      out  1  memory write strobe
//  ir_write       out  1  load instruction register
//  reg_dst        out  1  0: rt, 1: rd
//  mem_to_reg     out  1  0: ALUOut, 1: MDR
//  reg_write      out  1  register file write enable
//  alu_src_a      out  1  0: PC, 1: A
//  alu_src_b      out  2  00: B, 01: const 4, 10: sign-ext imm, 11: sign-ext imm<<2
//  alu_op         out  2  00: add, 01: sub, 10: use funct (to alu_control)
//  pc_src         out  2  00: ALU result, 01: ALUOut, 10: jump target
//  illegal_op     out  1  high while in ILLEGAL, or for the DECODE cycle of an unknown opcode
// BEHAVIOUR
//  Opcodes: RTYPE 000000, LW 100011, SW 101011, BEQ 000100, ADDI 001000, J 000010; others illegal.
//  States (4-bit): IDLE, FETCH, DECODE, MEMADR, MEMREAD, MEMWB, MEMWRITE, RTEXEC, RTWB,
//    BRANCH, ADDIEXEC, ADDIWB, JUMP, ILLEGAL.
//  Reset: rst_n=0 -> state=IDLE immediately (async); IDLE drives every output 0, alu_op=00.
//    First clk edge with rst_n=1: IDLE->FETCH. rst_n low in any state aborts it; no partial writes after.
//  Default for every output not listed in a state: 0.
//  FETCH: mem_read, ir_write, pc_write, alu_src_b=01, alu_op=00. Stays in FETCH while
//    MEM_WAIT && !mem_ready; ir_write/pc_write asserted only in the cycle mem_ready=1. -> DECODE.
//  DECODE: alu_src_b=11, alu_op=00 (branch target precompute). Next by opcode:
//    LW/SW->MEMADR, RTYPE->RTEXEC, BEQ->BRANCH, ADDI->ADDIEXEC, J->JUMP,
//    other->illegal_op=1; ILLEGAL if TRAP_ILLEGAL else FETCH.
//  MEMADR: alu_src_a=1, alu_src_b=10, alu_op=00; LW->MEMREAD, SW->MEMWRITE (opcode held by IR).
//  MEMREAD: mem_read, iord=1; wait on mem_ready as FETCH; ->MEMWB.
//  MEMWB: reg_write, mem_to_reg=1, reg_dst=0; ->FETCH.
//  MEMWRITE: iord=1; mem_write asserted every cycle in state; exit on mem_ready; ->FETCH.
//  RTEXEC: alu_src_a=1, alu_src_b=00, alu_op=10; ->RTWB.  RTWB: reg_write, reg_dst=1; ->FETCH.
//  BRANCH: alu_src_a=1, alu_src_b=00, alu_op=01, pc_write_cond, pc_src=01; ->FETCH.
//  ADDIEXEC: alu_src_a=1, alu_src_b=10, alu_op=00; ->ADDIWB.  ADDIWB: reg_write, reg_dst=0; ->FETCH.
//  JUMP: pc_write, pc_src=10; ->FETCH.  ILLEGAL: illegal_op=1, self-loop until rst_n.
//  Unused state encodings -> IDLE next cycle, all outputs 0.
//  Instruction cycles (MEM_WAIT=0): LW 5, SW/RTYPE/ADDI 4, BEQ/J 3. Each mem wait cycle adds 1.
//  Opcode is sampled only in DECODE/MEMADR; changes elsewhere have no effect.
// STRUCTURE
//  Shared package mips_ctrl_pkg: opcode constants, state encodings, alu_op codes (00/01/10,
//    also read by alu_control), alu_src_b/pc_src select codes.
//  One sub-module: mc_output_decode (combinational state -> control word); the top holds
//    state register and next-state logic.
// TESTING
//  rst_n=0 mid-MEMREAD -> state IDLE same cycle, all outputs 0; release -> FETCH after 1 edge.
//  MEM_WAIT=0, opcode=100011 (LW) -> FETCH,DECODE,MEMADR,MEMREAD,MEMWB; reg_write & mem_to_reg only in cycle 5.
//  opcode=000000 -> RTEXEC with alu_op=10, RTWB with reg_write=1, reg_dst=1; 4 cycles total.
//  opcode=000100 -> BRANCH: alu_op=01, pc_write_cond=1, pc_src=01; J: pc_write=1, pc_src=10; both 3 cycles.
//  MEM_WAIT=1, SW, mem_ready low 3 cycles in MEMWRITE -> mem_write held 4 cycles, then FETCH.
//  opcode=111111: TRAP_ILLEGAL=0 -> illegal_op pulse 1 cycle, back to FETCH; =1 -> ILLEGAL held until reset.

Source files
------------

// File: rtl/mips_ctrl_pkg.sv
// Shared encodings for the multicycle MIPS control path: opcodes, FSM states,
// ALU op codes (also consumed by alu_control) and datapath mux select codes.
package mips_ctrl_pkg;

    localparam int unsigned OPCODE_W = 6;
    localparam int unsigned STATE_W  = 4;
    localparam int unsigned ALU_OP_W = 2;
    localparam int unsigned SEL_W    = 2;

    localparam logic [OPCODE_W-1:0] OP_RTYPE = 6'b000000;
    localparam logic [OPCODE_W-1:0] OP_LW    = 6'b100011;
    localparam logic [OPCODE_W-1:0] OP_SW    = 6'b101011;
    localparam logic [OPCODE_W-1:0] OP_BEQ   = 6'b000100;
    localparam logic [OPCODE_W-1:0] OP_ADDI  = 6'b001000;
    localparam logic [OPCODE_W-1:0] OP_J     = 6'b000010;

    localparam logic [ALU_OP_W-1:0] ALU_OP_ADD   = 2'b00;
    localparam logic [ALU_OP_W-1:0] ALU_OP_SUB   = 2'b01;
    localparam logic [ALU_OP_W-1:0] ALU_OP_FUNCT = 2'b10;

    localparam logic [SEL_W-1:0] ALUB_REG     = 2'b00;
    localparam logic [SEL_W-1:0] ALUB_FOUR    = 2'b01;
    localparam logic [SEL_W-1:0] ALUB_IMM     = 2'b10;
    localparam logic [SEL_W-1:0] ALUB_IMM_SH2 = 2'b11;

    localparam logic [SEL_W-1:0] PCSRC_ALU    = 2'b00;
    localparam logic [SEL_W-1:0] PCSRC_ALUOUT = 2'b01;
    localparam logic [SEL_W-1:0] PCSRC_JUMP   = 2'b10;

    typedef enum logic [STATE_W-1:0] {
        S_IDLE     = 4'd0,
        S_FETCH    = 4'd1,
        S_DECODE   = 4'd2,
        S_MEMADR   = 4'd3,
        S_MEMREAD  = 4'd4,
        S_MEMWB    = 4'd5,
        S_MEMWRITE = 4'd6,
        S_RTEXEC   = 4'd7,
        S_RTWB     = 4'd8,
        S_BRANCH   = 4'd9,
        S_ADDIEXEC = 4'd10,
        S_ADDIWB   = 4'd11,
        S_JUMP     = 4'd12,
        S_ILLEGAL  = 4'd13
    } state_e;

    typedef struct packed {
        logic                pc_write;
        logic                pc_write_cond;
        logic                iord;
        logic                mem_read;
        logic                mem_write;
        logic                ir_write;
        logic                reg_dst;
        logic                mem_to_reg;
        logic                reg_write;
        logic                alu_src_a;
        logic [SEL_W-1:0]    alu_src_b;
        logic [ALU_OP_W-1:0] alu_op;
        logic [SEL_W-1:0]    pc_src;
        logic                illegal_op;
    } ctrl_word_t;

    function automatic logic is_legal_op(input logic [OPCODE_W-1:0] op);
        return (op == OP_RTYPE) || (op == OP_LW) || (op == OP_SW) ||
               (op == OP_BEQ)   || (op == OP_ADDI) || (op == OP_J);
    endfunction

endpackage

// File: rtl/mc_output_decode.sv
// Combinational state -> control word decode for the multicycle control FSM.
// Only the fetch write strobes and the decode-cycle illegal flag look past the state.
module mc_output_decode
    import mips_ctrl_pkg::*;
#(
    parameter bit MEM_WAIT = 1'b1
) (
    input  state_e               state_i,
    input  logic [OPCODE_W-1:0]  opcode_i,
    input  logic                 mem_ready_i,
    output ctrl_word_t           ctrl_o
);

    logic mem_done;
    assign mem_done = !MEM_WAIT || mem_ready_i;

    always_comb begin
        ctrl_o           = '0;
        ctrl_o.alu_src_b = ALUB_REG;
        ctrl_o.alu_op    = ALU_OP_ADD;
        ctrl_o.pc_src    = PCSRC_ALU;
        case (state_i)
            S_FETCH: begin
                ctrl_o.mem_read  = 1'b1;
                ctrl_o.alu_src_b = ALUB_FOUR;
                // IR and PC only update once the instruction word is actually back
                ctrl_o.ir_write  = mem_done;
                ctrl_o.pc_write  = mem_done;
            end
            S_DECODE: begin
                ctrl_o.alu_src_b  = ALUB_IMM_SH2;
                ctrl_o.illegal_op = !is_legal_op(opcode_i);
            end
            S_MEMADR, S_ADDIEXEC: begin
                ctrl_o.alu_src_a = 1'b1;
                ctrl_o.alu_src_b = ALUB_IMM;
            end
            S_MEMREAD: begin
                ctrl_o.mem_read = 1'b1;
                ctrl_o.iord     = 1'b1;
            end
            S_MEMWB: begin
                ctrl_o.reg_write  = 1'b1;
                ctrl_o.mem_to_reg = 1'b1;
            end
            S_MEMWRITE: begin
                ctrl_o.mem_write = 1'b1;
                ctrl_o.iord      = 1'b1;
            end
            S_RTEXEC: begin
                ctrl_o.alu_src_a = 1'b1;
                ctrl_o.alu_op    = ALU_OP_FUNCT;
            end
            S_RTWB: begin
                ctrl_o.reg_write = 1'b1;
                ctrl_o.reg_dst   = 1'b1;
            end
            S_BRANCH: begin
                ctrl_o.alu_src_a     = 1'b1;
                ctrl_o.alu_op        = ALU_OP_SUB;
                ctrl_o.pc_write_cond = 1'b1;
                ctrl_o.pc_src        = PCSRC_ALUOUT;
            end
            S_ADDIWB: begin
                ctrl_o.reg_write = 1'b1;
            end
            S_JUMP: begin
                ctrl_o.pc_write = 1'b1;
                ctrl_o.pc_src   = PCSRC_JUMP;
            end
            S_ILLEGAL: begin
                ctrl_o.illegal_op = 1'b1;
            end
            default: ;
        endcase
    end

endmodule

// File: rtl/multicycle_control.sv
// Main control FSM of the multicycle MIPS datapath: state register, next-state
// sequencing by opcode, and the Moore control word for the datapath and alu_control.
module multicycle_control
    import mips_ctrl_pkg::*;
#(
    parameter bit MEM_WAIT     = 1'b1,
    parameter bit TRAP_ILLEGAL = 1'b0
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic [OPCODE_W-1:0] opcode_i,
    input  logic                mem_ready_i,
    output logic                pc_write_o,
    output logic                pc_write_cond_o,
    output logic                iord_o,
    output logic                mem_read_o,
    output logic                mem_write_o,
    output logic                ir_write_o,
    output logic                reg_dst_o,
    output logic                mem_to_reg_o,
    output logic                reg_write_o,
    output logic                alu_src_a_o,
    output logic [SEL_W-1:0]    alu_src_b_o,
    output logic [ALU_OP_W-1:0] alu_op_o,
    output logic [SEL_W-1:0]    pc_src_o,
    output logic                illegal_op_o
);

    state_e     state_q, state_d;
    ctrl_word_t ctrl;
    logic       mem_done;

    assign mem_done = !MEM_WAIT || mem_ready_i;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:    state_d = S_FETCH;
            S_FETCH:   if (mem_done) state_d = S_DECODE;
            S_DECODE: begin
                case (opcode_i)
                    OP_LW, OP_SW: state_d = S_MEMADR;
                    OP_RTYPE:     state_d = S_RTEXEC;
                    OP_BEQ:       state_d = S_BRANCH;
                    OP_ADDI:      state_d = S_ADDIEXEC;
                    OP_J:         state_d = S_JUMP;
                    default:      state_d = TRAP_ILLEGAL ? S_ILLEGAL : S_FETCH;
                endcase
            end
            // opcode still held by the IR; anything else is abandoned back to fetch
            S_MEMADR: begin
                if (opcode_i == OP_LW) begin
                    state_d = S_MEMREAD;
                end else if (opcode_i == OP_SW) begin
                    state_d = S_MEMWRITE;
                end else begin
                    state_d = S_FETCH;
                end
            end
            S_MEMREAD:  if (mem_done) state_d = S_MEMWB;
            S_MEMWB:    state_d = S_FETCH;
            S_MEMWRITE: if (mem_done) state_d = S_FETCH;
            S_RTEXEC:   state_d = S_RTWB;
            S_RTWB:     state_d = S_FETCH;
            S_BRANCH:   state_d = S_FETCH;
            S_ADDIEXEC: state_d = S_ADDIWB;
            S_ADDIWB:   state_d = S_FETCH;
            S_JUMP:     state_d = S_FETCH;
            S_ILLEGAL:  state_d = S_ILLEGAL;
            default:    state_d = S_IDLE;
        endcase
    end

    mc_output_decode #(
        .MEM_WAIT (MEM_WAIT)
    ) u_output_decode (
        .state_i     (state_q),
        .opcode_i    (opcode_i),
        .mem_ready_i (mem_ready_i),
        .ctrl_o      (ctrl)
    );

    assign pc_write_o      = ctrl.pc_write;
    assign pc_write_cond_o = ctrl.pc_write_cond;
    assign iord_o          = ctrl.iord;
    assign mem_read_o      = ctrl.mem_read;
    assign mem_write_o     = ctrl.mem_write;
    assign ir_write_o      = ctrl.ir_write;
    assign reg_dst_o       = ctrl.reg_dst;
    assign mem_to_reg_o    = ctrl.mem_to_reg;
    assign reg_write_o     = ctrl.reg_write;
    assign alu_src_a_o     = ctrl.alu_src_a;
    assign alu_src_b_o     = ctrl.alu_src_b;
    assign alu_op_o        = ctrl.alu_op;
    assign pc_src_o        = ctrl.pc_src;
    assign illegal_op_o    = ctrl.illegal_op;

endmodule
